// File: rtl/ctr64_seq.sv
// ---------------------------------------------------------------------------
// ctr64_seq
//   Sequencer for the 64-state counter datapath. The 6-bit count is presented
//   as a 4-bit low digit (rg_a) and a 2-bit high digit (bit_a). The count runs
//   under start/stop/pause control up to a terminal value latched at start,
//   in one-shot or auto-reload mode, and each terminal event produces a
//   one-cycle registered done pulse.
//
// Optional feature:
//   CTR64_SEQ_PRESCALE_EN - when defined, the count advances only once every
//   PRESCALE cycles of RUN. When undefined, the count may advance on every
//   edge and PRESCALE is only range-checked.
//
// Ports:
//   clock     in   1  system clock, rising edge
//   rst       in   1  synchronous active-high reset
//   start     in   1  start request, honoured in IDLE and DONE only
//   stop      in   1  abort to IDLE from any state
//   pause     in   1  level, freezes the count while running
//   reload    in   1  1 = auto-reload, 0 = one-shot (latched at start)
//   tc_value  in   6  terminal count (latched at start)
//   rg_a      out  4  count[3:0]
//   bit_a     out  2  count[5:4]
//   busy      out  1  high in RUN or PAUSE
//   done      out  1  one-cycle pulse per terminal event
//   state     out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
//
// Control semantics: all control inputs are plain levels sampled on every
// rising edge. Per edge the priority is rst > stop > start > pause > count.
// There is no request/acknowledge handshake; a start seen in IDLE or DONE is
// accepted on that edge, and start is ignored while busy.
// ---------------------------------------------------------------------------
module ctr64_seq #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic       reload,
    input  logic [5:0] tc_value,
    output logic [3:0] rg_a,
    output logic [1:0] bit_a,
    output logic       busy,
    output logic       done,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    if ((PRESCALE < 2) || (PRESCALE > 16)) begin : g_bad_prescale
        $error("ctr64_seq: PRESCALE must be in 2..16");
    end

    state_t     cur_state;
    state_t     nxt_state;
    logic [5:0] count;
    logic [5:0] nxt_count;
    logic [5:0] tc_lat;
    logic [5:0] nxt_tc_lat;
    logic       mode_lat;
    logic       nxt_mode_lat;
    logic       nxt_done;
    logic       tick;
    // High on edges where RUN is actually counting (not leaving or pausing).
    logic       run_edge;

    assign run_edge = (cur_state == S_RUN) && !stop && !pause;

`ifdef CTR64_SEQ_PRESCALE_EN
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_cnt;

    // The prescaler is held at zero outside RUN/PAUSE so every new run starts
    // a full PRESCALE period before its first tick; PAUSE simply holds it.
    assign tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge clock) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if ((cur_state == S_IDLE) || (cur_state == S_DONE)) begin
            pre_cnt <= '0;
        end else if (run_edge) begin
            pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
        end
    end
`else
    assign tick = 1'b1;
`endif

    // Next-state, next-count and latch logic.
    always_comb begin
        nxt_state    = cur_state;
        nxt_count    = count;
        nxt_tc_lat   = tc_lat;
        nxt_mode_lat = mode_lat;
        nxt_done     = 1'b0;

        if (stop) begin
            // Abort suppresses done even if this edge would have been terminal.
            nxt_state = S_IDLE;
            nxt_count = 6'd0;
        end else begin
            case (cur_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        nxt_state    = S_RUN;
                        nxt_count    = 6'd0;
                        nxt_tc_lat   = tc_value;
                        nxt_mode_lat = reload;
                    end else if (cur_state == S_IDLE) begin
                        nxt_count = 6'd0;
                    end
                end
                S_RUN: begin
                    if (pause) begin
                        nxt_state = S_PAUSE;
                    end else if (run_edge && tick) begin
                        if (count == tc_lat) begin
                            nxt_done = 1'b1;
                            if (mode_lat) begin
                                nxt_count = 6'd0;
                            end else begin
                                nxt_state = S_DONE;
                            end
                        end else begin
                            // 6-bit add: rg_a carries into bit_a, 63 wraps to 0.
                            nxt_count = count + 6'd1;
                        end
                    end
                end
                S_PAUSE: begin
                    if (!pause) begin
                        nxt_state = S_RUN;
                    end
                end
                default: begin
                    nxt_state = S_IDLE;
                    nxt_count = 6'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            cur_state <= S_IDLE;
            count     <= 6'd0;
            tc_lat    <= 6'd0;
            mode_lat  <= 1'b0;
            done      <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            count     <= nxt_count;
            tc_lat    <= nxt_tc_lat;
            mode_lat  <= nxt_mode_lat;
            done      <= nxt_done;
        end
    end

    assign rg_a  = count[3:0];
    assign bit_a = count[5:4];
    assign busy  = (cur_state == S_RUN) || (cur_state == S_PAUSE);
    assign state = cur_state;

endmodule
